// File: rtl/kv_pkg.sv
// Types and constants shared by the KV line fetcher and the KVCache it serves.
package kv_pkg;

   localparam int unsigned KV_DATA_WIDTH = 32;
   localparam int unsigned KV_LINE_SIZE  = 4;
   localparam int unsigned LINE_BYTES    = KV_LINE_SIZE * KV_DATA_WIDTH / 8;
   localparam int unsigned OFFSET_BITS   = $clog2(LINE_BYTES);

   typedef enum logic [1:0] {StIdle, StFill, StResp} state_t;

   typedef logic [KV_DATA_WIDTH-1:0] line_t [KV_LINE_SIZE];

endpackage

// File: rtl/kv_line_fetcher.sv
// Line-fill engine: turns one cache fill request into LINE_SIZE pipelined word reads
// and hands the assembled line back to the cache.
module kv_line_fetcher
   import kv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned LINE_SIZE       = 4,
   parameter int unsigned MAX_OUTSTANDING = LINE_SIZE
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   output logic [DATA_WIDTH-1:0] o_resp_data [LINE_SIZE],
   output logic                  o_resp_valid,
   input  logic                  i_resp_ready,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_valid,
   input  logic                  i_mem_ready,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   input  logic                  i_mem_rvalid,
   output logic                  o_mem_rready
);

   localparam int unsigned CNT_W      = $clog2(LINE_SIZE) + 1;
   localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING) + 1;
   localparam int unsigned IDX_W      = $clog2(LINE_SIZE);
   localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int unsigned OFF_W      = IDX_W + BYTE_SHIFT;

   localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(LINE_SIZE - 1);
   localparam logic [CNT_W-1:0]      LINE_CNT  = CNT_W'(LINE_SIZE);
   localparam logic [OUT_W-1:0]      OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
   localparam logic [ADDR_WIDTH-1:0] BASE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]      rcv_cnt_q;
   logic [OUT_W-1:0]      out_q, out_d;
   logic [DATA_WIDTH-1:0] line_q [LINE_SIZE];
   logic                  issue_fire, rsp_fire;

   // Word offsets are OR-ed into the aligned base, so they can never carry out of the line.
   function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [CNT_W-1:0]      idx);
      return base | (ADDR_WIDTH'(idx[IDX_W-1:0]) << BYTE_SHIFT);
   endfunction

   always_comb begin
      issue_fire  = o_mem_valid & i_mem_ready;
      rsp_fire    = o_mem_rready & i_mem_rvalid;
      issue_cnt_d = issue_cnt_q + CNT_W'(issue_fire);
      out_d       = out_q;
      if (issue_fire && !rsp_fire) begin
         out_d = out_q + OUT_W'(1);
      end else if (!issue_fire && rsp_fire) begin
         out_d = out_q - OUT_W'(1);
      end
   end

   assign o_resp_data = line_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q      <= StIdle;
         base_q       <= '0;
         issue_cnt_q  <= '0;
         rcv_cnt_q    <= '0;
         out_q        <= '0;
         o_req_ready  <= 1'b1;
         o_resp_valid <= 1'b0;
         o_mem_valid  <= 1'b0;
         o_mem_rready <= 1'b0;
         o_mem_addr   <= '0;
         for (int i = 0; i < LINE_SIZE; i++) begin
            line_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_req_valid) begin
                  base_q       <= i_req_addr & BASE_MASK;
                  issue_cnt_q  <= '0;
                  rcv_cnt_q    <= '0;
                  out_q        <= '0;
                  o_req_ready  <= 1'b0;
                  o_mem_valid  <= 1'b1;
                  o_mem_addr   <= i_req_addr & BASE_MASK;
                  o_mem_rready <= 1'b1;
                  state_q      <= StFill;
               end
            end
            StFill: begin
               issue_cnt_q <= issue_cnt_d;
               out_q       <= out_d;
               if (rsp_fire) begin
                  line_q[rcv_cnt_q[IDX_W-1:0]] <= i_mem_rdata;
                  rcv_cnt_q                    <= rcv_cnt_q + CNT_W'(1);
               end
               // A pending read keeps its address: issue_cnt_d only moves on a handshake.
               o_mem_valid <= (issue_cnt_d < LINE_CNT) && (out_d < OUT_MAX);
               o_mem_addr  <= word_addr(base_q, issue_cnt_d);
               if (rsp_fire && (rcv_cnt_q == LAST_IDX)) begin
                  o_mem_valid  <= 1'b0;
                  o_mem_rready <= 1'b0;
                  o_resp_valid <= 1'b1;
                  state_q      <= StResp;
               end
            end
            StResp: begin
               if (i_resp_ready) begin
                  o_resp_valid <= 1'b0;
                  o_req_ready  <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kv_line_fetcher.sv
// Scoreboard bench for kv_line_fetcher: instance 0 uses the default outstanding limit,
// instance 1 allows a single outstanding read.
module tb_kv_line_fetcher;
   import kv_pkg::*;

   typedef struct {
      int          due;
      logic [31:0] data;
   } pend_t;

   logic clk = 1'b0;
   logic rstn;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req_valid [2];
   logic [31:0] req_addr [2];
   logic        req_ready [2];
   line_t       resp_data [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] mem_addr [2];
   logic        mem_valid [2];
   logic        mem_ready [2];
   logic [31:0] rdata [2];
   logic        rvalid [2];
   logic        rready [2];

   // Per-instance test configuration and scoreboard state.
   int           lat_v [2];
   int           mode_v [2];
   int           stall_v [2];
   int           rx_cnt [2];
   int           done_cnt [2];
   logic [31:0]  dataq [2][$];
   logic [31:0]  addr_q [2][$];
   logic [127:0] exp_q [2][$];
   int           exp_lat_q [2][$];
   pend_t        pend_q [2][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned MAXO = (g == 0) ? 4 : 1;

      kv_line_fetcher #(
         .DATA_WIDTH     (32),
         .ADDR_WIDTH     (32),
         .LINE_SIZE      (4),
         .MAX_OUTSTANDING(MAXO)
      ) u_dut (
         .i_clk       (clk),
         .i_rstn      (rstn),
         .i_req_addr  (req_addr[g]),
         .i_req_valid (req_valid[g]),
         .o_req_ready (req_ready[g]),
         .o_resp_data (resp_data[g]),
         .o_resp_valid(resp_valid[g]),
         .i_resp_ready(resp_ready[g]),
         .o_mem_addr  (mem_addr[g]),
         .o_mem_valid (mem_valid[g]),
         .i_mem_ready (mem_ready[g]),
         .i_mem_rdata (rdata[g]),
         .i_mem_rvalid(rvalid[g]),
         .o_mem_rready(rready[g])
      );

      int stall_cnt = 0;

      // Memory and cache drivers: update just after each rising edge.
      always begin
         @(posedge clk);
         #1;
         mem_ready[g] = (mode_v[g] == 0) ? 1'b1 : cyc[0];
         if (rstn && pend_q[g].size() > 0 && pend_q[g][0].due <= cyc) begin
            rvalid[g] = 1'b1;
            rdata[g]  = pend_q[g][0].data;
         end else begin
            rvalid[g] = 1'b0;
            rdata[g]  = 32'hDEAD_BEEF;
         end
         if (resp_valid[g]) begin
            resp_ready[g] = (stall_cnt >= stall_v[g]);
            stall_cnt++;
         end else begin
            resp_ready[g] = 1'b1;
            stall_cnt     = 0;
         end
      end

      int           acc_cyc = 0;
      int           issued = 0;
      int           outs;
      bit           in_resp = 0;
      bit           after_hs = 0;
      bit           hold_pend = 0;
      logic [31:0]  hold_addr;
      logic [31:0]  wd;
      logic [127:0] e;

      // Monitor: everything is stable at the falling edge; a handshake seen here fires next edge.
      always begin
         @(negedge clk);
         if (!rstn) begin
            pend_q[g].delete();
            in_resp   = 0;
            after_hs  = 0;
            hold_pend = 0;
            issued    = 0;
         end else begin
            if (after_hs) begin
               chk("req_ready_after_resp", 32'(req_ready[g]), 32'd1);
               after_hs = 0;
            end
            if (req_valid[g] && req_ready[g]) acc_cyc = cyc;
            if (hold_pend) begin
               chk("mem_valid_hold", 32'(mem_valid[g]), 32'd1);
               chk("mem_addr_hold", mem_addr[g], hold_addr);
            end
            hold_pend = mem_valid[g] && !mem_ready[g];
            hold_addr = mem_addr[g];
            outs = pend_q[g].size();
            if (rvalid[g] && rready[g]) begin
               void'(pend_q[g].pop_front());
               rx_cnt[g]++;
               outs--;
            end
            if (mem_valid[g] && mem_ready[g]) begin
               issued++;
               chk("outstanding_limit", 32'(outs < int'(MAXO)), 32'd1);
               if (addr_q[g].size() == 0) chk("extra_issue", mem_addr[g], 32'hFFFF_FFFF);
               else chk("mem_addr", mem_addr[g], addr_q[g].pop_front());
               wd = (dataq[g].size() > 0) ? dataq[g].pop_front() : 32'hBAD0_BAD0;
               pend_q[g].push_back('{due: cyc + lat_v[g], data: wd});
            end
            if (resp_valid[g]) begin
               chk("req_ready_in_resp", 32'(req_ready[g]), 32'd0);
               chk("rready_in_resp", 32'(rready[g]), 32'd0);
               if (exp_q[g].size() == 0) begin
                  chk("unexpected_line", 32'd1, 32'd0);
               end else begin
                  e = exp_q[g][0];
                  if (!in_resp) begin
                     in_resp = 1;
                     if (exp_lat_q[g][0] >= 0)
                        chk("resp_latency", 32'(cyc - acc_cyc), 32'(exp_lat_q[g][0]));
                  end
                  for (int i = 0; i < 4; i++) chk("resp_data", resp_data[g][i], e[32*i +: 32]);
                  if (resp_ready[g]) begin
                     void'(exp_q[g].pop_front());
                     void'(exp_lat_q[g].pop_front());
                     chk("issue_count", 32'(issued), 32'd4);
                     issued   = 0;
                     in_resp  = 0;
                     after_hs = 1;
                     done_cnt[g]++;
                  end
               end
            end
         end
      end
   end

   task automatic check_reset(input int g);
      chk("rst_req_ready", 32'(req_ready[g]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[g]), 32'd0);
      chk("rst_mem_valid", 32'(mem_valid[g]), 32'd0);
      chk("rst_mem_rready", 32'(rready[g]), 32'd0);
      chk("rst_mem_addr", mem_addr[g], 32'd0);
      for (int i = 0; i < 4; i++) chk("rst_resp_data", resp_data[g][i], 32'd0);
   endtask

   task automatic start_req(input int g, input logic [31:0] addr, input logic [127:0] line,
                            input int lat, input int mode, input int stall, input int exp_lat);
      logic [31:0] base;
      int          n;
      lat_v[g]   = lat;
      mode_v[g]  = mode;
      stall_v[g] = stall;
      base       = addr & 32'hFFFF_FFF0;
      for (int i = 0; i < 4; i++) begin
         dataq[g].push_back(line[32*i +: 32]);
         addr_q[g].push_back(base + 32'(4 * i));
      end
      exp_q[g].push_back(line);
      exp_lat_q[g].push_back(exp_lat);
      @(posedge clk);
      #1;
      req_valid[g] = 1'b1;
      req_addr[g]  = addr;
      n = 0;
      @(negedge clk);
      while (!req_ready[g] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("req_accept_timeout", 32'(req_ready[g]), 32'd1);
      @(posedge clk);
      #1;
      req_valid[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input int target);
      int n = 0;
      while (done_cnt[g] < target && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("line_done", 32'(done_cnt[g]), 32'(target));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rx0;
      int n;
      rstn = 1'b0;
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b0;
         req_addr[g]  = '0;
         lat_v[g]     = 1;
         mode_v[g]    = 0;
         stall_v[g]   = 0;
         rx_cnt[g]    = 0;
         done_cnt[g]  = 0;
      end
      repeat (3) @(negedge clk);
      check_reset(0);
      check_reset(1);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Basic fill with exact latency.
      start_req(0, 32'h1000_1000, {32'h0505_0505, 32'h5555_5555, 32'h5555_0000, 32'h0000_5555},
                1, 0, 0, 6);
      wait_done(0, 1);
      // Unaligned request address starts at the line base.
      start_req(0, 32'h1000_100C, {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000},
                1, 0, 0, 6);
      wait_done(0, 2);
      // Memory backpressure toggling every cycle.
      start_req(0, 32'h4000_0020, {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
                1, 1, 0, -1);
      wait_done(0, 3);
      // Cache stalls the line for five cycles.
      start_req(0, 32'h5000_0030, {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001},
                2, 0, 5, 7);
      wait_done(0, 4);

      // Reset after two beats; partial line must vanish.
      rx0 = rx_cnt[0];
      start_req(0, 32'h3000_0100, {32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000},
                1, 0, 0, -1);
      n = 0;
      while (rx_cnt[0] < rx0 + 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("beats_before_reset", 32'(rx_cnt[0] - rx0), 32'd2);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      check_reset(0);
      dataq[0].delete();
      addr_q[0].delete();
      exp_q[0].delete();
      exp_lat_q[0].delete();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      start_req(0, 32'h2000_0040, {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000},
                1, 0, 0, 6);
      wait_done(0, 5);

      // Single outstanding read with three-cycle memory latency: four serial round trips.
      start_req(1, 32'h6000_0050, {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000},
                3, 0, 0, 17);
      wait_done(1, 1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kv_line_fetcher.md
Name: kv_line_fetcher

Overview:
- Memory-side fill engine directly downstream of the KVCache fetch port.
- Accepts one line-fill request (address) from the cache and issues LINE_SIZE pipelined word reads to the memory bus.
- Collects the in-order read responses into a line buffer and returns the whole line to the cache on its fetch-data handshake.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDR_WIDTH, 32, byte-address width.
- LINE_SIZE, 4, words per cache line; must be a power of two ≥ 2.
- MAX_OUTSTANDING, LINE_SIZE, maximum memory reads issued but not yet answered; range 1..LINE_SIZE.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_req_addr  in  ADDR_WIDTH  line-fill byte address from cache (connects to cache o_fetch_addr).
- i_req_valid  in  1  fill request valid (cache o_fetch_valid).
- o_req_ready  out  1  request accepted when valid&ready (cache i_fetch_ready).
- o_resp_data  out  DATA_WIDTH x LINE_SIZE  unpacked line, index 0 = lowest address (cache i_fetch_data).
- o_resp_valid  out  1  line valid (cache i_fetch_valid).
- i_resp_ready  in  1  cache takes line (cache o_fetch_ready).
- o_mem_addr  out  ADDR_WIDTH  word read address.
- o_mem_valid  out  1  read request valid.
- i_mem_ready  in  1  memory accepts read.
- i_mem_rdata  in  DATA_WIDTH  read data.
- i_mem_rvalid  in  1  read data valid; responses return in issue order.
- o_mem_rready  out  1  fetcher accepts read data.

Behaviour:
- Reset (async assert, sync deassert by the flops): state=IDLE; o_req_ready=1; o_resp_valid=0; o_mem_valid=0; o_mem_rready=0; o_mem_addr=0; o_resp_data all 0; counters 0.
- Line base = i_req_addr with the low log2(LINE_SIZE*DATA_WIDTH/8) bits cleared. The base is latched at accept.
- Word i address = base + i*(DATA_WIDTH/8). The offset never carries out of the line.
- FSM states:
  - IDLE: o_req_ready=1. On valid&ready, latch the base, clear issue_cnt, rcv_cnt and outstanding, then go to FILL.
  - FILL: o_mem_valid=1 while issue_cnt<LINE_SIZE and outstanding<MAX_OUTSTANDING. o_mem_addr = word(issue_cnt). o_mem_rready=1.
    - Issue handshake increments issue_cnt.
    - Response handshake writes i_mem_rdata into buf[rcv_cnt] and increments rcv_cnt.
    - Issue and response in the same cycle leave outstanding unchanged.
    - When the final response is accepted (rcv_cnt==LINE_SIZE-1 & rvalid), go to RESP on the next edge.
  - RESP: o_resp_valid=1, o_resp_data=buf, held stable until i_resp_ready. On handshake go to IDLE.
- o_req_ready=0 outside IDLE. A new request is accepted no earlier than the cycle after the response handshake (one bubble cycle).
- o_mem_valid, once asserted, holds with a stable o_mem_addr until i_mem_ready (no retraction).
- o_mem_rready=0 outside FILL. Responses arriving in IDLE/RESP are a protocol error and are ignored (no state change).
- Latency: with i_mem_ready=1 and rvalid one cycle after issue, accept at cycle 0, issues at cycles 1..4, data at 2..5, o_resp_valid at cycle 6.
- Reset mid-fill: state returns to IDLE immediately and the partial line is discarded. The memory is reset on the same i_rstn, so no stale responses remain in flight.
- Width: issue_cnt and rcv_cnt are $clog2(LINE_SIZE)+1 bits. outstanding is $clog2(MAX_OUTSTANDING)+1 bits.

Decomposition:
- Shared package kv_pkg holds:
  - the state enum (IDLE, FILL, RESP);
  - localparam LINE_BYTES = LINE_SIZE*DATA_WIDTH/8 and OFFSET_BITS = $clog2(LINE_BYTES);
  - a line typedef (DATA_WIDTH x LINE_SIZE array) shared with KVCache.
- No sub-module. The FSM, counters and line buffer form one module of about 200 lines.

Test Plan:
- Basic fill: i_req_addr=0x1000_1000; memory returns 0x0000_5555, 0x5555_0000, 0x5555_5555, 0x0505_0505 one cycle after each issue. Required: o_mem_addr sequence 0x1000_1000/04/08/0C; o_resp_valid at cycle 6; o_resp_data[0..3] match in order.
- Unaligned request: i_req_addr=0x1000_100C. Required: first o_mem_addr=0x1000_1000, last 0x1000_100C; line order unchanged.
- Memory backpressure: i_mem_ready toggles 0/1 each cycle. Required: o_mem_valid and o_mem_addr held while ready=0; exactly 4 issues; correct line.
- Outstanding limit: MAX_OUTSTANDING=1, rvalid delayed 3 cycles. Required: no second issue before the first response; total 4 round trips.
- Cache stall: i_resp_ready=0 for 5 cycles in RESP. Required: o_resp_valid and o_resp_data stable; o_req_ready=0 until handshake, then 1 the next cycle.
- Reset mid-fill: assert i_rstn=0 after 2 beats. Required: all outputs at reset values immediately; a following request to 0x2000_0040 completes with only new data.
